// File: rtl/ov7670_pixel_stream.sv
// OV7670 capture-side pipeline: vsync/href framing, pixel assembly, decimate/clip, output FIFO.
// Define OV7670_STREAM_STATS_EN to add the frame_count/drop_count ports.
module ov7670_pixel_stream #(
   parameter int FRAME_W         = 640,
   parameter int FRAME_H         = 480,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int DECIM           = 1,
   parameter int FIFO_DEPTH      = 16,
   parameter int X_W             = 10,
   parameter int Y_W             = 9
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cam_vsync,
   input  logic                         cam_href,
   input  logic                         cam_byte_valid,
   input  logic [7:0]                   cam_data,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [8*BYTES_PER_PIXEL-1:0] out_pixel,
   output logic [X_W-1:0]               out_x,
   output logic [Y_W-1:0]               out_y,
   output logic                         out_sof,
   output logic                         frame_done,
   output logic                         overflow
`ifdef OV7670_STREAM_STATS_EN
   ,
   output logic [15:0]                  frame_count,
   output logic [15:0]                  drop_count
`endif
);

   localparam int PIXEL_W = 8 * BYTES_PER_PIXEL;
   localparam int SW      = (BYTES_PER_PIXEL > 1) ? PIXEL_W - 8 : 1;
   localparam int CW      = $clog2(FRAME_W + 1);
   localparam int RW      = $clog2(FRAME_H + 1);
   localparam int DSH     = $clog2(DECIM);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int EW      = 1 + Y_W + X_W + PIXEL_W;

   typedef enum logic [1:0] {WAIT_VSYNC, WAIT_FRAME, ACTIVE} state_t;

   state_t             state;
   logic               href_q;
   logic [1:0]         byte_cnt;
   logic [CW-1:0]      col;
   logic [RW-1:0]      row;
   logic [SW-1:0]      pix_sr;
   logic [PIXEL_W-1:0] pix_next;
   logic               push_req;
   logic [EW-2:0]      push_data;
   logic               sof_armed;

   logic byte_take, pix_done, keep, line_end, enter_active;

   assign byte_take    = (state == ACTIVE) && !cam_vsync && cam_href && cam_byte_valid;
   assign pix_done     = byte_take && (byte_cnt == 2'(BYTES_PER_PIXEL - 1));
   assign line_end     = (state == ACTIVE) && !cam_vsync && href_q && !cam_href;
   assign enter_active = (state == WAIT_FRAME) && !cam_vsync;
   assign keep = (col < CW'(FRAME_W)) && (row < RW'(FRAME_H)) &&
                 ((col & CW'(DECIM - 1)) == '0) && ((row & RW'(DECIM - 1)) == '0);

   // Earlier bytes sit above the newest one, so the first byte ends up in the MSBs.
   generate
      if (BYTES_PER_PIXEL == 1) begin : g_one_byte
         assign pix_next = cam_data;
      end else begin : g_multi_byte
         assign pix_next = {pix_sr, cam_data};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= WAIT_VSYNC;
         href_q     <= 1'b0;
         byte_cnt   <= '0;
         col        <= '0;
         row        <= '0;
         pix_sr     <= '0;
         push_req   <= 1'b0;
         push_data  <= '0;
         frame_done <= 1'b0;
      end else begin
         href_q     <= cam_href;
         push_req   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            WAIT_VSYNC: if (cam_vsync) state <= WAIT_FRAME;
            WAIT_FRAME: begin
               if (!cam_vsync) begin
                  byte_cnt <= '0;
                  col      <= '0;
                  row      <= '0;
                  state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (cam_vsync) begin
                  frame_done <= 1'b1;
                  state      <= WAIT_FRAME;
               end else if (line_end) begin
                  byte_cnt <= '0;
                  col      <= '0;
                  if (col != '0 && row != RW'(FRAME_H)) row <= row + RW'(1);
               end else if (byte_take) begin
                  pix_sr <= pix_next[SW-1:0];
                  if (pix_done) begin
                     byte_cnt  <= '0;
                     if (col != CW'(FRAME_W)) col <= col + CW'(1);
                     push_req  <= keep;
                     push_data <= {Y_W'(row >> DSH), X_W'(col >> DSH), pix_next};
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            default: state <= WAIT_VSYNC;
         endcase
      end
   end

   // out_valid/out_ready: an entry transfers on a clk edge where both are high;
   // the head entry holds steady while out_valid is high and out_ready is low.
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, push_ok, drop;

   assign out_valid = (count != '0);
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   assign push_ok   = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;
   assign head      = mem[rd_ptr];
   assign {out_sof, out_y, out_x, out_pixel} = out_valid ? head : '0;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {sof_armed, push_data};
   end

   // sof stays armed until a pixel is actually accepted, so drops pass it on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         sof_armed <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + (AW+1)'(1);
         else if (!push_ok && pop) count <= count - (AW+1)'(1);
         if (drop) overflow <= 1'b1;
         if (enter_active)  sof_armed <= 1'b1;
         else if (push_ok)  sof_armed <= 1'b0;
      end
   end

`ifdef OV7670_STREAM_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_count <= '0;
         drop_count  <= '0;
      end else begin
         if (frame_done) frame_count <= frame_count + 16'd1;
         if (drop)       drop_count  <= drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ov7670_pixel_stream.sv
// Directed bench for ov7670_pixel_stream: small-frame instance (clip/overflow) and a DECIM=2 instance.
module tb_ov7670_pixel_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b0;
   logic       href = 1'b0;
   logic       bv = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready = 1'b0;

   logic        va, sa, fda, ova;
   logic [15:0] pa;
   logic [2:0]  xa;
   logic [3:0]  ya;
   logic        vb, sb, fdb, ovb;
   logic [15:0] pb;
   logic [2:0]  xb;
   logic [2:0]  yb;
`ifdef OV7670_STREAM_STATS_EN
   logic [15:0] fca, dca, fcb, dcb;
`endif

   ov7670_pixel_stream #(.FRAME_W(4), .FRAME_H(8), .BYTES_PER_PIXEL(2), .DECIM(1),
                         .FIFO_DEPTH(4), .X_W(3), .Y_W(4)) dut_a (
      .clk(clk), .reset(rst), .cam_vsync(vsync), .cam_href(href), .cam_byte_valid(bv),
      .cam_data(data), .out_ready(ready), .out_valid(va), .out_pixel(pa), .out_x(xa),
      .out_y(ya), .out_sof(sa), .frame_done(fda), .overflow(ova)
`ifdef OV7670_STREAM_STATS_EN
      , .frame_count(fca), .drop_count(dca)
`endif
   );

   ov7670_pixel_stream #(.FRAME_W(8), .FRAME_H(8), .BYTES_PER_PIXEL(2), .DECIM(2),
                         .FIFO_DEPTH(16), .X_W(3), .Y_W(3)) dut_b (
      .clk(clk), .reset(rst), .cam_vsync(vsync), .cam_href(href), .cam_byte_valid(bv),
      .cam_data(data), .out_ready(ready), .out_valid(vb), .out_pixel(pb), .out_x(xb),
      .out_y(yb), .out_sof(sb), .frame_done(fdb), .overflow(ovb)
`ifdef OV7670_STREAM_STATS_EN
      , .frame_count(fcb), .drop_count(dcb)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [23:0] got_a[$];
   logic [23:0] got_b[$];
   int fd_cnt = 0;
   int fd_double = 0;
   logic fd_prev = 1'b0;
   logic [7:0] line_buf [64];

   // Records every transfer the consumer would see on each instance.
   always @(negedge clk) begin
      if (va && ready) got_a.push_back({sa, ya, xa, pa});
      if (vb && ready) got_b.push_back({1'b0, sb, yb, xb, pb});
      if (fda) fd_cnt++;
      if (fda && fd_prev) fd_double++;
      fd_prev = fda;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_start();
      vsync = 1'b1; step(); step();
      vsync = 1'b0; step(); step();
   endtask

   task automatic frame_end();
      vsync = 1'b1; step(); step();
   endtask

   task automatic send_line(input int n);
      href = 1'b1; step();
      for (int i = 0; i < n; i++) begin
         bv = 1'b1; data = line_buf[i]; step();
      end
      bv = 1'b0; href = 1'b0; step(); step();
   endtask

   task automatic test_reset();
      step(); step();
      total++;
      if ({va, sa, fda, ova, pa, xa, ya} !== '0) begin
         bad++; $display("FAIL reset_a got=%h want=0", {va, sa, fda, ova, pa, xa, ya});
      end
      total++;
      if ({vb, sb, fdb, ovb, pb, xb, yb} !== '0) begin
         bad++; $display("FAIL reset_b got=%h want=0", {vb, sb, fdb, ovb, pb, xb, yb});
      end
`ifdef OV7670_STREAM_STATS_EN
      total++;
      if ({fca, dca} !== 32'd0) begin
         bad++; $display("FAIL reset_stats got=%h want=0", {fca, dca});
      end
`endif
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic [23:0] exp [4];
      logic [23:0] g;
      int base;
      exp[0] = {1'b1, 4'd0, 3'd0, 16'h1234};
      exp[1] = {1'b0, 4'd0, 3'd1, 16'h5678};
      exp[2] = {1'b0, 4'd0, 3'd2, 16'h9ABC};
      exp[3] = {1'b0, 4'd0, 3'd3, 16'hDEF0};
      ready = 1'b1;
      frame_start();
      base = got_a.size();
      href = 1'b1; step();
      bv = 1'b1; data = 8'h12; step();
      data = 8'h34; step();
      total++;
      if (va !== 1'b0) begin bad++; $display("FAIL basic_lat1 got=%b want=0", va); end
      data = 8'h56; step();
      total++;
      if ({va, sa, pa} !== {1'b1, 1'b1, 16'h1234}) begin
         bad++; $display("FAIL basic_lat2 got=%h want=%h", {va, sa, pa}, {1'b1, 1'b1, 16'h1234});
      end
      data = 8'h78; step();
      data = 8'h9A; step();
      data = 8'hBC; step();
      data = 8'hDE; step();
      data = 8'hF0; step();
      bv = 1'b0; href = 1'b0;
      repeat (6) step();
      total++;
      if (got_a.size() - base != 4) begin
         bad++; $display("FAIL basic_count got=%0d want=4", got_a.size() - base);
      end
      for (int i = 0; i < 4; i++) begin
         g = (base + i < got_a.size()) ? got_a[base + i] : 'x;
         total++;
         if (g !== exp[i]) begin bad++; $display("FAIL basic_px%0d got=%h want=%h", i, g, exp[i]); end
      end
      frame_end();
   endtask

   task automatic test_odd_byte();
      logic [23:0] exp [2];
      logic [23:0] g;
      int base;
      exp[0] = {1'b1, 4'd0, 3'd0, 16'hAABB};
      exp[1] = {1'b0, 4'd1, 3'd0, 16'hDDEE};
      ready = 1'b1;
      frame_start();
      base = got_a.size();
      line_buf[0] = 8'hAA; line_buf[1] = 8'hBB; line_buf[2] = 8'hCC;
      send_line(3);
      line_buf[0] = 8'hDD; line_buf[1] = 8'hEE;
      send_line(2);
      repeat (6) step();
      total++;
      if (got_a.size() - base != 2) begin
         bad++; $display("FAIL odd_count got=%0d want=2", got_a.size() - base);
      end
      for (int i = 0; i < 2; i++) begin
         g = (base + i < got_a.size()) ? got_a[base + i] : 'x;
         total++;
         if (g !== exp[i]) begin bad++; $display("FAIL odd_px%0d got=%h want=%h", i, g, exp[i]); end
      end
      frame_end();
   endtask

   task automatic test_overflow();
      logic [23:0] exp [4];
      logic [23:0] g;
      int base;
      exp[0] = {1'b1, 4'd0, 3'd0, 16'h0102};
      exp[1] = {1'b0, 4'd0, 3'd1, 16'h0304};
      exp[2] = {1'b0, 4'd0, 3'd2, 16'h0506};
      exp[3] = {1'b0, 4'd0, 3'd3, 16'h0708};
      ready = 1'b0;
      frame_start();
      base = got_a.size();
      for (int i = 0; i < 8; i++) line_buf[i] = 8'(i + 1);
      send_line(8);
      for (int i = 0; i < 4; i++) line_buf[i] = 8'(i + 9);
      send_line(4);
      step(); step();
      total++;
      if ({va, ova} !== 2'b11) begin bad++; $display("FAIL ovf_flags got=%b want=11", {va, ova}); end
`ifdef OV7670_STREAM_STATS_EN
      total++;
      if (dca !== 16'd2) begin bad++; $display("FAIL ovf_drop_count got=%0d want=2", dca); end
`endif
      repeat (3) step();
      total++;
      if ({sa, xa, pa} !== {1'b1, 3'd0, 16'h0102}) begin
         bad++; $display("FAIL ovf_hold got=%h want=%h", {sa, xa, pa}, {1'b1, 3'd0, 16'h0102});
      end
      ready = 1'b1;
      repeat (8) step();
      total++;
      if (got_a.size() - base != 4) begin
         bad++; $display("FAIL ovf_count got=%0d want=4", got_a.size() - base);
      end
      for (int i = 0; i < 4; i++) begin
         g = (base + i < got_a.size()) ? got_a[base + i] : 'x;
         total++;
         if (g !== exp[i]) begin bad++; $display("FAIL ovf_px%0d got=%h want=%h", i, g, exp[i]); end
      end
      total++;
      if ({va, ova} !== 2'b01) begin bad++; $display("FAIL ovf_after got=%b want=01", {va, ova}); end
      frame_end();
   endtask

   task automatic test_reset_midline();
      logic [23:0] g;
      int base;
      ready = 1'b0;
      frame_start();
      for (int i = 0; i < 6; i++) line_buf[i] = 8'h11 * 8'(i + 1);
      send_line(6);
      step();
      total++;
      if (va !== 1'b1) begin bad++; $display("FAIL rstmid_queued got=%b want=1", va); end
      href = 1'b1; step();
      bv = 1'b1; data = 8'h77; step();
      bv = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if ({va, ova, sa} !== 3'b000) begin
         bad++; $display("FAIL rstmid_async got=%b want=000", {va, ova, sa});
      end
`ifdef OV7670_STREAM_STATS_EN
      total++;
      if ({fca, dca} !== 32'd0) begin bad++; $display("FAIL rstmid_stats got=%h want=0", {fca, dca}); end
`endif
      step();
      rst = 1'b0; href = 1'b0;
      ready = 1'b1;
      base = got_a.size();
      line_buf[0] = 8'h88; line_buf[1] = 8'h99; line_buf[2] = 8'hAA; line_buf[3] = 8'hBB;
      send_line(4);
      send_line(4);
      repeat (4) step();
      total++;
      if (got_a.size() - base != 0 || va !== 1'b0) begin
         bad++; $display("FAIL rstmid_ignored got=%0d want=0", got_a.size() - base);
      end
      frame_start();
      line_buf[0] = 8'hC1; line_buf[1] = 8'hC2;
      send_line(2);
      repeat (4) step();
      g = (base < got_a.size()) ? got_a[base] : 'x;
      total++;
      if (got_a.size() - base != 1 || g !== {1'b1, 4'd0, 3'd0, 16'hC1C2}) begin
         bad++; $display("FAIL rstmid_resume got=%h want=%h", g, {1'b1, 4'd0, 3'd0, 16'hC1C2});
      end
      frame_end();
   endtask

   task automatic test_two_frames();
      logic [23:0] exp [8];
      logic [23:0] g;
      int base, fd_base;
      exp[0] = {1'b1, 4'd0, 3'd0, 16'h2021};
      exp[1] = {1'b0, 4'd0, 3'd1, 16'h2223};
      exp[2] = {1'b0, 4'd0, 3'd2, 16'h2425};
      exp[3] = {1'b0, 4'd0, 3'd3, 16'h2627};
      exp[4] = {1'b1, 4'd0, 3'd0, 16'h4041};
      exp[5] = {1'b0, 4'd0, 3'd1, 16'h4243};
      exp[6] = {1'b0, 4'd0, 3'd2, 16'h4445};
      exp[7] = {1'b0, 4'd0, 3'd3, 16'h4647};
      ready = 1'b1;
      base = got_a.size();
      fd_base = fd_cnt;
      for (int f = 0; f < 2; f++) begin
         frame_start();
         for (int k = 0; k < 12; k++) line_buf[k] = ((f == 0) ? 8'h20 : 8'h40) + 8'(k);
         send_line(12);
         repeat (4) step();
         frame_end();
      end
      repeat (4) step();
      total++;
      if (fd_cnt - fd_base != 2) begin
         bad++; $display("FAIL frames_done got=%0d want=2", fd_cnt - fd_base);
      end
      total++;
      if (fd_double != 0) begin bad++; $display("FAIL frames_pulse_width got=%0d want=0", fd_double); end
      total++;
      if (got_a.size() - base != 8) begin
         bad++; $display("FAIL frames_count got=%0d want=8", got_a.size() - base);
      end
      for (int i = 0; i < 8; i++) begin
         g = (base + i < got_a.size()) ? got_a[base + i] : 'x;
         total++;
         if (g !== exp[i]) begin bad++; $display("FAIL frames_px%0d got=%h want=%h", i, g, exp[i]); end
      end
`ifdef OV7670_STREAM_STATS_EN
      total++;
      if ({fca, dca} !== {16'd3, 16'd0}) begin
         bad++; $display("FAIL frames_stats got=%h want=%h", {fca, dca}, {16'd3, 16'd0});
      end
`endif
   endtask

   task automatic test_decim();
      logic [23:0] exp [8];
      logic [23:0] g;
      int base;
      exp[0] = {1'b0, 1'b1, 3'd0, 3'd0, 16'h0000};
      exp[1] = {1'b0, 1'b0, 3'd0, 3'd1, 16'h0002};
      exp[2] = {1'b0, 1'b0, 3'd0, 3'd2, 16'h0004};
      exp[3] = {1'b0, 1'b0, 3'd0, 3'd3, 16'h0006};
      exp[4] = {1'b0, 1'b0, 3'd1, 3'd0, 16'h0200};
      exp[5] = {1'b0, 1'b0, 3'd1, 3'd1, 16'h0202};
      exp[6] = {1'b0, 1'b0, 3'd1, 3'd2, 16'h0204};
      exp[7] = {1'b0, 1'b0, 3'd1, 3'd3, 16'h0206};
      rst = 1'b1; step(); rst = 1'b0; step();
      ready = 1'b1;
      frame_start();
      base = got_b.size();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            line_buf[2*c]     = 8'(r);
            line_buf[2*c + 1] = 8'(c);
         end
         send_line(16);
      end
      repeat (6) step();
      total++;
      if (got_b.size() - base != 8) begin
         bad++; $display("FAIL decim_count got=%0d want=8", got_b.size() - base);
      end
      for (int i = 0; i < 8; i++) begin
         g = (base + i < got_b.size()) ? got_b[base + i] : 'x;
         total++;
         if (g !== exp[i]) begin bad++; $display("FAIL decim_px%0d got=%h want=%h", i, g, exp[i]); end
      end
      frame_end();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_odd_byte();
      test_overflow();
      test_reset_midline();
      test_two_frames();
      test_decim();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ov7670_pixel_stream.md
Name: ov7670_pixel_stream

Overview:
Parametrised camera-side pixel pipeline that sits between the OV7670 byte capture and a display or memory consumer.
- Frames the raw byte stream using vsync and href.
- Assembles bytes into pixels and tracks x/y coordinates.
- Decimates and clips to a target window.
- Buffers pixels in a FIFO and presents them on a valid/ready interface with coordinates, so the consumer no longer needs a frame RAM between camera and screen.

Parameters:
FRAME_W, 640, active pixels per line accepted; columns >= FRAME_W are dropped.
FRAME_H, 480, active lines per frame accepted; rows >= FRAME_H are dropped.
BYTES_PER_PIXEL, 2, camera bytes per pixel (1..3); PIXEL_W = 8*BYTES_PER_PIXEL.
DECIM, 1, power-of-2 decimation factor (1, 2, 4) applied to both x and y.
FIFO_DEPTH, 16, output FIFO entries; power of 2, >= 2.
X_W, 10, width of out_x; must hold FRAME_W/DECIM-1.
Y_W, 9, width of out_y; must hold FRAME_H/DECIM-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
cam_vsync  in  1  camera vsync, already synchronised to clk; high = vertical blanking.
cam_href  in  1  camera href, synchronised; high = active line.
cam_byte_valid  in  1  one-cycle strobe per captured camera byte.
cam_data  in  8  camera byte, qualified by cam_byte_valid.
out_ready  in  1  consumer ready.
out_valid  out  1  FIFO head valid.
out_pixel  out  PIXEL_W  pixel; first byte received occupies the MSBs.
out_x  out  X_W  decimated column of out_pixel.
out_y  out  Y_W  decimated row of out_pixel.
out_sof  out  1  high with the first pixel of each frame.
frame_done  out  1  one-cycle pulse when vsync rises at the end of an ACTIVE frame.
overflow  out  1  sticky; set when a pixel is dropped because the FIFO is full.

Behaviour:
Reset values:
- All outputs 0, FIFO empty, FSM in WAIT_VSYNC, all counters 0.

FSM:
- WAIT_VSYNC: wait for cam_vsync=1, then go to WAIT_FRAME.
- WAIT_FRAME: on cam_vsync=0, clear row/col/byte counters, arm sof, go to ACTIVE.
- ACTIVE: capture. On cam_vsync=1, pulse frame_done and go to WAIT_FRAME.
- A reset or power-up mid-frame therefore ignores the partial frame.

Byte assembly:
- In ACTIVE with cam_href=1 and cam_byte_valid=1, shift cam_data into the pixel register and increment byte_cnt.
- When byte_cnt reaches BYTES_PER_PIXEL-1, a pixel is complete: byte_cnt returns to 0 and col increments (saturating at FRAME_W).
- cam_byte_valid while cam_href=0 is ignored.

Line end (href falling edge, detected from the registered previous href):
- Discard any partial pixel (byte_cnt := 0).
- col := 0.
- If col>0, row increments (saturating at FRAME_H).

Keep rule:
- Push a completed pixel iff col<FRAME_W, row<FRAME_H, col%DECIM==0 and row%DECIM==0.
- out_x = col/DECIM, out_y = row/DECIM, computed on the pre-increment col.

FIFO:
- Each entry holds {sof, y, x, pixel}. Push occurs in the cycle after the last byte strobe.
- Show-ahead read, so an empty-FIFO latency of 2 clk from the last byte strobe to out_valid=1.
- Pop when out_valid and out_ready.
- Full with a simultaneous pop: push accepted.
- Full without a pop: the pixel is dropped and overflow := 1. The sof flag is not consumed by a dropped pixel, so it moves to the next accepted pixel.
- overflow is cleared only by reset.

out_sof:
- Set on the first pushed pixel after entering ACTIVE.

Output stability:
- out_pixel, out_x, out_y and out_sof hold stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro: OV7670_STREAM_STATS_EN.
- Defined: adds output ports frame_count[15:0] and drop_count[15:0], both reset to 0.
  - frame_count increments with each frame_done pulse.
  - drop_count increments per FIFO-full drop.
  - Both wrap at 0xFFFF->0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset, then vsync 1→0, one line of 4 pixels (bytes 0x12,0x34,0x56,0x78,…), out_ready=1 → pixels 0x1234,0x5678,… at x=0..3, y=0; out_sof only on the first; first out_valid 2 clk after the 2nd byte strobe.
2. DECIM=2, 4 lines × 8 pixels → 4 pixels per kept line from rows 0 and 2 only, out_x=0..3, out_y=0,1; rows 1 and 3 produce nothing.
3. FIFO_DEPTH=4, out_ready=0, 6 pixels → out_valid stays 1, 4 entries retained, overflow=1 (drop_count=2 with STATS_EN); releasing out_ready drains exactly 4 entries in order.
4. Line with 3 bytes (BYTES_PER_PIXEL=2) then href falls → 1 pixel emitted, odd byte discarded, next line starts at x=0, y=1.
5. Assert reset mid-line with 3 entries queued → out_valid=0 immediately, overflow=0; bytes arriving while vsync stays low are ignored until a full vsync high→low cycle.
6. Two complete frames → frame_done pulses twice, one cycle each; out_sof appears once per frame; FRAME_W=4 with 6-pixel lines clips columns 4 and 5.
